pipeline_hazard_control: RTL and testbench

//  Central sequencer for the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/hazard_load_use.sv | 14 +
 rtl/pipeline_hazard_control.sv | 149 ++++++++++++++
 tb/tb_pipeline_hazard_control.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: per-latch command encoding and hazard-sequencer states.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        PIPE_ENABLE = 2'd0,
        PIPE_STALL  = 2'd1,
        PIPE_NOP    = 2'd2
    } pipe_state_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } hz_state_t;

    // A write to $zero never creates a dependency.
    function automatic logic reg_dep(input logic [4:0] wsel, input logic [4:0] src);
        return (wsel != 5'd0) && (wsel == src);
    endfunction

endpackage

// File: rtl/hazard_load_use.sv
// Load-use dependency detector between the EX load and the ID source operands.
module hazard_load_use
    import cpu_types_pkg::*;
(
    input  logic       ld_ex_i,
    input  logic [4:0] wsel_ex_i,
    input  logic [4:0] rs_id_i,
    input  logic [4:0] rt_id_i,
    output logic       hazard_o
);

    assign hazard_o = ld_ex_i & (reg_dep(wsel_ex_i, rs_id_i) | reg_dep(wsel_ex_i, rt_id_i));

endmodule

// File: rtl/pipeline_hazard_control.sv
// Pipeline latch sequencer: memory waits, redirect flushes, load-use stalls, halt,
// plus saturating stall/flush performance counters.
module pipeline_hazard_control
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dREN_mem,
    input  logic             dWEN_mem,
    input  logic             branch_taken_mem,
    input  logic             jump_ex,
    input  logic             halt_mem,
    input  logic             dREN_ex,
    input  logic [4:0]       regWSEL_ex,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    output logic             pc_en,
    output pipe_state_t      fd_state,
    output pipe_state_t      de_state,
    output pipe_state_t      em_state,
    output pipe_state_t      mw_state,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_t        state_q, state_d;
    logic             halted_q;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             load_use_s;
    logic             dmem_pend_s;
    logic             flush_ev_s;
    logic             stall_ev_s;

    hazard_load_use u_load_use (
        .ld_ex_i   (dREN_ex),
        .wsel_ex_i (regWSEL_ex),
        .rs_id_i   (rs_id),
        .rt_id_i   (rt_id),
        .hazard_o  (load_use_s)
    );

    assign dmem_pend_s = (dREN_mem | dWEN_mem) & ~dhit;

    // Priority encoder producing latch commands and next FSM state.
    always_comb begin
        state_d    = state_q;
        fd_state   = PIPE_ENABLE;
        de_state   = PIPE_ENABLE;
        em_state   = PIPE_ENABLE;
        mw_state   = PIPE_ENABLE;
        pc_en      = 1'b1;
        flush_ev_s = 1'b0;
        if (RST) begin
            state_d  = RUN;
            fd_state = PIPE_NOP;
            de_state = PIPE_NOP;
            em_state = PIPE_NOP;
            mw_state = PIPE_NOP;
            pc_en    = 1'b0;
        end else begin
            case (state_q)
                HALT: begin
                    fd_state = PIPE_STALL;
                    de_state = PIPE_STALL;
                    em_state = PIPE_STALL;
                    mw_state = PIPE_STALL;
                    pc_en    = 1'b0;
                end
                RUN, DWAIT: begin
                    if (halt_mem) begin
                        state_d  = HALT;
                        fd_state = PIPE_NOP;
                        de_state = PIPE_NOP;
                        em_state = PIPE_NOP;
                        pc_en    = 1'b0;
                    end else if (dmem_pend_s) begin
                        state_d  = DWAIT;
                        fd_state = PIPE_STALL;
                        de_state = PIPE_STALL;
                        em_state = PIPE_STALL;
                        mw_state = PIPE_NOP;
                        pc_en    = 1'b0;
                    end else begin
                        state_d = RUN;
                        // Redirects load the PC even without ihit so the target is fetched.
                        if (branch_taken_mem) begin
                            fd_state   = PIPE_NOP;
                            de_state   = PIPE_NOP;
                            em_state   = PIPE_NOP;
                            flush_ev_s = 1'b1;
                        end else if (jump_ex) begin
                            fd_state   = PIPE_NOP;
                            de_state   = PIPE_NOP;
                            flush_ev_s = 1'b1;
                        end else if (load_use_s) begin
                            fd_state = PIPE_STALL;
                            de_state = PIPE_NOP;
                            pc_en    = 1'b0;
                        end else if (!ihit) begin
                            fd_state = PIPE_NOP;
                            pc_en    = 1'b0;
                        end else begin
                            pc_en = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d  = RUN;
                    fd_state = PIPE_NOP;
                    de_state = PIPE_NOP;
                    em_state = PIPE_NOP;
                    mw_state = PIPE_NOP;
                    pc_en    = 1'b0;
                end
            endcase
        end
    end

    assign stall_ev_s = ~RST & ~pc_en & (state_q != HALT);

    // FSM state, halted flag and saturating performance counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == HALT);
            if (stall_ev_s && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_ev_s && (flush_q != {CNT_W{1'b1}})) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign halted    = halted_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_control.sv
// Self-checking bench: directed vector table, corner sequences and randomized traffic
// against a rule-level reference model; a narrow-counter instance checks saturation.
module tb_pipeline_hazard_control;
    import cpu_types_pkg::*;

    typedef struct packed {
        logic       rst, ihit, dhit, dren_mem, dwen_mem, br, jmp, halt, dren_ex;
        logic [4:0] wsel, rs, rt;
    } in_t;

    typedef struct packed {
        pipe_state_t fd, de, em, mw;
        logic        pc;
    } exp_t;

    typedef struct {
        in_t  in;
        exp_t ex;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST, ihit, dhit, dREN_mem, dWEN_mem, branch_taken_mem, jump_ex, halt_mem, dREN_ex;
    logic [4:0]  regWSEL_ex, rs_id, rt_id;
    logic        pc_en, halted, pc_en_n, halted_n;
    pipe_state_t fd_state, de_state, em_state, mw_state;
    pipe_state_t fd_n, de_n, em_n, mw_n;
    logic [31:0] stall_cnt, flush_cnt;
    logic [2:0]  stall_n, flush_n;

    int          n_tests = 0;
    int          n_fail  = 0;

    logic        m_halted;
    logic [31:0] m_stall, m_flush;
    int          ms_stall, ms_flush;

    always #5 CLK = ~CLK;

    pipeline_hazard_control dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem),
        .branch_taken_mem(branch_taken_mem), .jump_ex(jump_ex), .halt_mem(halt_mem),
        .dREN_ex(dREN_ex), .regWSEL_ex(regWSEL_ex), .rs_id(rs_id), .rt_id(rt_id),
        .pc_en(pc_en), .fd_state(fd_state), .de_state(de_state), .em_state(em_state),
        .mw_state(mw_state), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_control #(.CNT_W(3)) dut_sat (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem),
        .branch_taken_mem(branch_taken_mem), .jump_ex(jump_ex), .halt_mem(halt_mem),
        .dREN_ex(dREN_ex), .regWSEL_ex(regWSEL_ex), .rs_id(rs_id), .rt_id(rt_id),
        .pc_en(pc_en_n), .fd_state(fd_n), .de_state(de_n), .em_state(em_n),
        .mw_state(mw_n), .halted(halted_n), .stall_cnt(stall_n), .flush_cnt(flush_n)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input bit ih, input bit dh, input bit drm, input bit dwm, input bit br,
                               input bit jp, input bit hl, input bit dre, input logic [4:0] ws,
                               input logic [4:0] rs, input logic [4:0] rt);
        in_t v;
        v = '{rst: 1'b0, ihit: ih, dhit: dh, dren_mem: drm, dwen_mem: dwm, br: br, jmp: jp,
              halt: hl, dren_ex: dre, wsel: ws, rs: rs, rt: rt};
        return v;
    endfunction

    function automatic exp_t ex4(input pipe_state_t a, input pipe_state_t b, input pipe_state_t c,
                                 input pipe_state_t d, input logic pc);
        exp_t e;
        e = '{fd: a, de: b, em: c, mw: d, pc: pc};
        return e;
    endfunction

    // Reference: command set chosen straight from the ordered hazard rules.
    function automatic exp_t model_out(input in_t v, input logic hlt);
        logic pend, dep;
        pend = (v.dren_mem || v.dwen_mem) && !v.dhit;
        dep  = v.dren_ex && (v.wsel != 5'd0) && (v.wsel == v.rs || v.wsel == v.rt);
        if (v.rst)            return ex4(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_NOP, 1'b0);
        if (hlt)              return ex4(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_STALL, 1'b0);
        if (v.halt)           return ex4(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_ENABLE, 1'b0);
        if (pend)             return ex4(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_NOP, 1'b0);
        if (v.br)             return ex4(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_ENABLE, 1'b1);
        if (v.jmp)            return ex4(PIPE_NOP, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, 1'b1);
        if (dep)              return ex4(PIPE_STALL, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, 1'b0);
        if (!v.ihit)          return ex4(PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b0);
        return ex4(PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b1);
    endfunction

    task automatic apply(input in_t v);
        RST = v.rst; ihit = v.ihit; dhit = v.dhit; dREN_mem = v.dren_mem; dWEN_mem = v.dwen_mem;
        branch_taken_mem = v.br; jump_ex = v.jmp; halt_mem = v.halt; dREN_ex = v.dren_ex;
        regWSEL_ex = v.wsel; rs_id = v.rs; rt_id = v.rt;
    endtask

    // One clock: drive, compare against the model, then advance the model.
    task automatic cycle(input in_t v);
        exp_t e;
        logic pend, stall_ev, flush_ev;
        @(negedge CLK);
        apply(v);
        #1;
        e = model_out(v, m_halted);
        check("fd_state", fd_state, e.fd);
        check("de_state", de_state, e.de);
        check("em_state", em_state, e.em);
        check("mw_state", mw_state, e.mw);
        check("pc_en", pc_en, e.pc);
        check("halted", halted, m_halted);
        check("stall_cnt", stall_cnt, m_stall);
        check("flush_cnt", flush_cnt, m_flush);
        check("stall_cnt_sat", 32'(stall_n), 32'(ms_stall));
        check("flush_cnt_sat", 32'(flush_n), 32'(ms_flush));
        pend     = (v.dren_mem || v.dwen_mem) && !v.dhit;
        stall_ev = !v.rst && !m_halted && !e.pc;
        flush_ev = !v.rst && !m_halted && !v.halt && !pend && (v.br || v.jmp);
        if (v.rst) begin
            m_halted = 1'b0; m_stall = 32'd0; m_flush = 32'd0; ms_stall = 0; ms_flush = 0;
        end else begin
            if (stall_ev && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
            if (flush_ev && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 32'd1;
            if (stall_ev && ms_stall < 7) ms_stall++;
            if (flush_ev && ms_flush < 7) ms_flush++;
            m_halted = m_halted | v.halt;
        end
    endtask

    task automatic do_reset();
        in_t r;
        r = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        r.rst = 1'b1;
        cycle(r);
    endtask

    initial begin
        vec_t tbl[12];
        in_t  idle, v, rv;

        idle = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        rv = idle;
        rv.rst = 1'b1;
        apply(rv);
        repeat (2) @(posedge CLK);
        m_halted = 1'b0; m_stall = 32'd0; m_flush = 32'd0; ms_stall = 0; ms_flush = 0;

        tbl[0]  = '{mk(1,0,0,0,0,0,0,0, 5'd0, 5'd0, 5'd0), ex4(PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b1)};
        tbl[1]  = '{mk(0,0,0,0,0,0,0,0, 5'd0, 5'd0, 5'd0), ex4(PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b0)};
        tbl[2]  = '{mk(1,0,0,0,0,0,0,1, 5'd5, 5'd1, 5'd5), ex4(PIPE_STALL, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, 1'b0)};
        tbl[3]  = '{mk(1,0,0,0,0,0,0,1, 5'd0, 5'd0, 5'd0), ex4(PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b1)};
        tbl[4]  = '{mk(1,0,0,0,0,0,0,1, 5'd7, 5'd7, 5'd3), ex4(PIPE_STALL, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, 1'b0)};
        tbl[5]  = '{mk(0,0,0,0,0,1,0,0, 5'd0, 5'd0, 5'd0), ex4(PIPE_NOP, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, 1'b1)};
        tbl[6]  = '{mk(0,0,0,0,1,1,0,0, 5'd0, 5'd0, 5'd0), ex4(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_ENABLE, 1'b1)};
        tbl[7]  = '{mk(1,0,1,0,1,0,0,0, 5'd0, 5'd0, 5'd0), ex4(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_NOP, 1'b0)};
        tbl[8]  = '{mk(1,1,0,1,0,0,0,0, 5'd0, 5'd0, 5'd0), ex4(PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b1)};
        tbl[9]  = '{mk(1,0,1,0,0,1,0,1, 5'd4, 5'd4, 5'd4), ex4(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_NOP, 1'b0)};
        tbl[10] = '{mk(1,1,1,0,0,1,0,0, 5'd0, 5'd0, 5'd0), ex4(PIPE_NOP, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, 1'b1)};
        tbl[11] = '{mk(1,0,0,0,0,0,0,0, 5'd6, 5'd6, 5'd6), ex4(PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b1)};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].in);
            check($sformatf("vec%0d_cmds", i), 32'({fd_state, de_state, em_state, mw_state, pc_en}),
                  32'({tbl[i].ex.fd, tbl[i].ex.de, tbl[i].ex.em, tbl[i].ex.mw, tbl[i].ex.pc}));
        end

        // Data-memory wait of three cycles, then completion.
        do_reset();
        v = mk(1,0,1,0,0,0,0,0, 5'd0, 5'd0, 5'd0);
        repeat (3) cycle(v);
        v.dhit = 1'b1;
        cycle(v);
        cycle(idle);
        check("dwait_stall_cnt", stall_cnt, 32'd3);

        // Branch and jump together with no fetch hit.
        do_reset();
        cycle(mk(0,0,0,0,1,1,0,0, 5'd0, 5'd0, 5'd0));
        check("br_jmp_pc_en", pc_en, 1'b1);
        cycle(idle);
        check("br_jmp_flush_cnt", flush_cnt, 32'd1);

        // Halt is terminal regardless of later inputs.
        do_reset();
        cycle(mk(1,0,0,0,0,0,1,0, 5'd0, 5'd0, 5'd0));
        check("halt_entry_mw", mw_state, PIPE_ENABLE);
        for (int i = 0; i < 10; i++) begin
            cycle(mk(i[0], i[1], 1'b0, 1'b0, 1'b0, i[2], 1'b0, 1'b0, 5'd0, 5'd0, 5'd0));
            check("halt_hold", 32'({halted, fd_state, pc_en}), 32'({1'b1, PIPE_STALL, 1'b0}));
        end

        // Reset taken in the middle of a memory wait.
        do_reset();
        v = mk(1,0,1,0,0,0,0,0, 5'd0, 5'd0, 5'd0);
        repeat (2) cycle(v);
        do_reset();
        check("rst_mid_dwait_fd", fd_state, PIPE_NOP);
        cycle(idle);
        check("rst_after_stall_cnt", stall_cnt, 32'd0);
        check("rst_after_fd", fd_state, PIPE_ENABLE);

        // Saturation on the narrow-counter instance.
        do_reset();
        repeat (10) cycle(mk(0,0,0,0,0,0,0,0, 5'd0, 5'd0, 5'd0));
        repeat (9) cycle(mk(1,0,0,0,0,1,0,0, 5'd0, 5'd0, 5'd0));
        cycle(idle);
        check("sat_stall_hold", 32'(stall_n), 32'd7);
        check("sat_flush_hold", 32'(flush_n), 32'd7);
        check("wide_stall_cnt", stall_cnt, 32'd10);
        check("wide_flush_cnt", flush_cnt, 32'd9);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            v = mk(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 79) == 0), ($urandom_range(0, 2) == 0),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            v.rst = ($urandom_range(0, 49) == 0);
            cycle(v);
        end
        cycle(idle);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
